regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 5, meaning register address width.
REQ-002 SHALL have parameter M, default 32, meaning register data width.
REQ-003 SHALL have parameter L, default 32, meaning number of registers cleared at init.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0_valid  input  1, req0_addr  input  N, req0_data  input  M: writeback request 0 (ALU path).
REQ-007 SHALL have ports req1_valid  input  1, req1_addr  input  N, req1_data  input  M: writeback request 1 (load path).
REQ-008 SHALL have ports req0_ready, req1_ready  output  1 each: request accepted this cycle.
REQ-009 SHALL have ports rf_we  output  1, rf_a3  output  N, rf_wd3  output  M: drive register file write port.
REQ-010 SHALL have port init_done  output  1: clear sequence complete, requests accepted.
REQ-011 SHALL have port conflict_cnt  output  16: saturating count of contention cycles.

Function
REQ-012 SHALL implement two states, INIT and RUN; reset forces INIT.
REQ-013 In INIT: rf_we=1, rf_a3=clear counter, rf_wd3=0; counter increments each cycle from 0.
REQ-014 INIT -> RUN at the edge ending the cycle in which counter = L-1; init_done=1 from that edge, held until reset.
REQ-015 In INIT both readys SHALL be 0; requests ignored, no conflict counting.
REQ-016 In RUN, a request SHALL be accepted on the edge where valid and ready are both 1.
REQ-017 readyX is combinational: RUN, reqX_valid, and (other valid=0 or priority pointer = X).
REQ-018 Priority pointer: reset value 0; after any grant to requester X it SHALL point to the other requester (round-robin).
REQ-019 Accepted request SHALL be registered; rf_we=1, rf_a3=addr, rf_wd3=data in the cycle immediately after acceptance (latency 1); rf_we=0 in RUN cycles with no prior acceptance.
REQ-020 Accepted request with addr = 0 SHALL complete handshake but produce rf_we=0 (x0 write dropped).
REQ-021 At most one request accepted per cycle; loser holds valid/addr/data stable and is granted the next cycle.
REQ-022 conflict_cnt SHALL increment in each RUN cycle with both valids = 1, saturating at 16'hFFFF.
REQ-023 Address arithmetic: clear counter N+1 bits wide to avoid wrap ambiguity when L = 2^N.

Reset
REQ-024 On reset cycle edge: state INIT, counter 0, pointer 0, pending write cleared, conflict_cnt 0, init_done 0.
REQ-025 Reset during RUN with a pending write SHALL cancel it; that write never reaches rf_we.
REQ-026 Reset during INIT SHALL restart clearing at address 0.
REQ-027 While reset is high, rf_we SHALL be 0 and both readys 0.

Verification
REQ-028 Release reset, no requests -> rf_we=1 for exactly L=32 cycles, rf_a3 0..31, rf_wd3=0, then init_done=1, rf_we=0.
REQ-029 RUN, req0 only, addr 5 data 32'hDEAD_BEEF -> req0_ready=1 same cycle; next cycle rf_we=1, rf_a3=5, rf_wd3=32'hDEAD_BEEF.
REQ-030 RUN, both valid held 4 cycles (addr 3 / addr 7) -> grants 0,1,0,1; rf_a3 sequence 3,7,3,7 one cycle later; conflict_cnt=4.
REQ-031 RUN, req1 addr 0 data 32'h1 -> req1_ready=1, rf_we stays 0 next cycle.
REQ-032 Accept req0 addr 9, assert reset next cycle -> rf_we=0, no write to 9; INIT restarts at address 0.
REQ-033 Force both valid 70000 RUN cycles -> conflict_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: clears L registers after reset, then
// grants two writeback requesters round-robin with a one-cycle registered write.
module regfile_write_arbiter #(
  parameter int unsigned N = 5,
  parameter int unsigned M = 32,
  parameter int unsigned L = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_addr,
  input  logic [M-1:0] req0_data,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_addr,
  input  logic [M-1:0] req1_data,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         rf_we,
  output logic [N-1:0] rf_a3,
  output logic [M-1:0] rf_wd3,
  output logic         init_done,
  output logic [15:0]  conflict_cnt
);

  localparam int unsigned CW = N + 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(L - 1);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] clr_q, clr_d;
  logic          ptr_q, ptr_d;
  logic          pend_we_q, pend_we_d;
  logic [N-1:0]  pend_addr_q, pend_addr_d;
  logic [M-1:0]  pend_data_q, pend_data_d;
  logic [15:0]   conf_q, conf_d;
  logic          done_q, done_d;

  logic run_c;
  logic gnt0_c;
  logic gnt1_c;

  // Grants are combinational so the requester sees ready in the same cycle.
  always_comb begin
    run_c  = (state_q == ST_RUN) && !reset;
    gnt0_c = run_c && req0_valid && (!req1_valid || !ptr_q);
    gnt1_c = run_c && req1_valid && (!req0_valid || ptr_q);
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    ptr_d       = ptr_q;
    pend_we_d   = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    conf_d      = conf_q;
    done_d      = done_q;
    if (reset) begin
      state_d     = ST_INIT;
      clr_d       = '0;
      ptr_d       = 1'b0;
      pend_addr_d = '0;
      pend_data_d = '0;
      conf_d      = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_d = clr_q + CW'(1);
          if (clr_q == CLR_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            clr_d   = '0;
          end
        end
        default: begin
          if (gnt0_c) begin
            pend_we_d   = (req0_addr != '0);
            pend_addr_d = req0_addr;
            pend_data_d = req0_data;
            ptr_d       = 1'b1;
          end else if (gnt1_c) begin
            pend_we_d   = (req1_addr != '0);
            pend_addr_d = req1_addr;
            pend_data_d = req1_data;
            ptr_d       = 1'b0;
          end
          if (req0_valid && req1_valid && (conf_q != 16'hFFFF)) begin
            conf_d = conf_q + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    clr_q       <= clr_d;
    ptr_q       <= ptr_d;
    pend_we_q   <= pend_we_d;
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
    conf_q      <= conf_d;
    done_q      <= done_d;
  end

  // Write port is forced quiet while reset is asserted.
  always_comb begin
    req0_ready   = gnt0_c;
    req1_ready   = gnt1_c;
    rf_we        = 1'b0;
    rf_a3        = '0;
    rf_wd3       = '0;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        rf_we = 1'b1;
        rf_a3 = clr_q[N-1:0];
      end else begin
        rf_we  = pend_we_q;
        rf_a3  = pend_addr_q;
        rf_wd3 = pend_data_q;
      end
    end
    init_done    = done_q;
    conflict_cnt = conf_q;
  end

endmodule
